// File: rtl/sam_video_pkg.sv
// Shared types for the SAM Coupe video path: line buffer word and scanline modes.
package sam_video_pkg;

    localparam int SAM_LINE_LENGTH = 768;
    localparam int SAM_DW          = 6;

    typedef struct packed {
        logic [SAM_DW-1:0] r;
        logic [SAM_DW-1:0] g;
        logic [SAM_DW-1:0] b;
        logic              blank;
    } rgbb_t;

    typedef enum logic [1:0] {
        NONE,
        P75,
        P50,
        P25
    } scanline_mode_t;

    function automatic logic [SAM_DW-1:0] scanline_dim(input logic [SAM_DW-1:0] c,
                                                       input scanline_mode_t mode);
        logic [SAM_DW-1:0] res;
        unique case (mode)
            NONE:    res = c;
            P75:     res = c - (c >> 2);
            P50:     res = c >> 1;
            P25:     res = c >> 2;
            default: res = c;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sam_line_ram.sv
// Ping-pong line store: two banks of LINE_LENGTH words, one write and one registered read port.
module sam_line_ram
    import sam_video_pkg::*;
#(
    parameter int LINE_LENGTH = SAM_LINE_LENGTH,
    parameter int AW          = $clog2(LINE_LENGTH)
) (
    input  logic          clk_sys,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  rgbb_t         wr_data,
    input  logic          re,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output rgbb_t         rd_data
);

    localparam logic [AW:0] BANK_OFS = (AW + 1)'(LINE_LENGTH);

    rgbb_t mem [2*LINE_LENGTH];

    logic [AW:0] widx;
    logic [AW:0] ridx;

    assign widx = {1'b0, wr_addr} + (wr_bank ? BANK_OFS : '0);
    assign ridx = {1'b0, rd_addr} + (rd_bank ? BANK_OFS : '0);

    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[widx] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[ridx];
        end
    end

endmodule

// File: rtl/sam_scandoubler.sv
// 15.6 kHz to 31.2 kHz line doubler: each stored input line is replayed twice at ce_pix2.
// Define SAM_SCANDOUBLER_SCANLINES_EN to dim the second replay according to the scanlines input.
module sam_scandoubler
    import sam_video_pkg::*;
#(
    parameter int LINE_LENGTH = SAM_LINE_LENGTH,
    parameter int DW          = SAM_DW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          ce_pix2,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          hblank_in,
    input  logic          vblank_in,
    input  logic [DW-1:0] r_in,
    input  logic [DW-1:0] g_in,
    input  logic [DW-1:0] b_in,
    input  logic [1:0]    scanlines,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] g_out,
    output logic [DW-1:0] b_out,
    output logic          hs_out,
    output logic          vs_out,
    output logic          de_out,
    output logic          ce_pix_out
);

    localparam int PW = $clog2(LINE_LENGTH + 1);
    localparam int AW = $clog2(LINE_LENGTH);
    localparam logic [PW-1:0] LEN_MAX = PW'(LINE_LENGTH);

    logic          hs_in_q;
    logic [PW-1:0] ipix;
    logic [PW-1:0] ilen;
    logic [PW-1:0] hscnt;
    logic [PW-1:0] hslen;
    logic          wbank;
    logic          hs_rise;
    logic          line_start;

    assign hs_rise    = hs_in & ~hs_in_q;
    assign line_start = ce_pix & hs_rise;

    // ipix saturates at LEN_MAX, so latching it directly gives min(ipix, LINE_LENGTH).
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_in_q <= 1'b0;
            ipix    <= '0;
            ilen    <= '0;
            hscnt   <= '0;
            hslen   <= '0;
            wbank   <= 1'b0;
        end else if (ce_pix) begin
            hs_in_q <= hs_in;
            if (hs_rise) begin
                ilen  <= ipix;
                ipix  <= '0;
                wbank <= ~wbank;
                hscnt <= PW'(1);
            end else begin
                if (ipix != LEN_MAX) ipix <= ipix + 1'b1;
                if (hs_in && hscnt != LEN_MAX) hscnt <= hscnt + 1'b1;
                if (!hs_in && hs_in_q) hslen <= hscnt;
            end
        end
    end

    logic  ram_we;
    rgbb_t wr_data;
    rgbb_t rd_data;

    assign ram_we  = ce_pix & ~reset & (ipix < LEN_MAX);
    assign wr_data = '{r: r_in, g: g_in, b: b_in, blank: hblank_in | vblank_in};

    logic [PW-1:0] opix;
    logic          oline;
    logic          vs_pre;
    logic [AW-1:0] rd_addr;

    // Past the end of the buffer opix is parked; the read is don't-care since de is low there.
    assign rd_addr = (opix < LEN_MAX) ? opix[AW-1:0] : '0;

    sam_line_ram #(
        .LINE_LENGTH (LINE_LENGTH),
        .AW          (AW)
    ) u_line_ram (
        .clk_sys (clk_sys),
        .we      (ram_we),
        .wr_bank (wbank),
        .wr_addr (ipix[AW-1:0]),
        .wr_data (wr_data),
        .re      (ce_pix2),
        .rd_bank (~wbank),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Second replay never wraps again; opix free-runs until the next input line.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            opix   <= '0;
            oline  <= 1'b0;
            vs_pre <= 1'b0;
        end else if (ce_pix2) begin
            if (line_start) begin
                opix   <= '0;
                oline  <= 1'b0;
                vs_pre <= vs_in;
            end else if (!oline && ilen != '0 && opix == ilen - 1'b1) begin
                opix  <= '0;
                oline <= 1'b1;
            end else if (opix != LEN_MAX) begin
                opix <= opix + 1'b1;
            end
        end
    end

    logic hs_d1;
    logic vs_d1;
    logic in_d1;
    logic oline_d1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_d1    <= 1'b0;
            vs_d1    <= 1'b0;
            in_d1    <= 1'b0;
            oline_d1 <= 1'b0;
        end else if (ce_pix2) begin
            hs_d1    <= opix < hslen;
            vs_d1    <= vs_pre;
            in_d1    <= opix < ilen;
            oline_d1 <= oline;
        end
    end

    scanline_mode_t mode;
    logic           de_next;

`ifdef SAM_SCANDOUBLER_SCANLINES_EN
    always_comb begin
        mode = NONE;
        if (oline_d1) mode = scanline_mode_t'(scanlines);
    end
`else
    logic unused_scanlines;
    assign unused_scanlines = ^{scanlines, oline_d1};
    assign mode = NONE;
`endif

    assign de_next = in_d1 & ~rd_data.blank;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            de_out     <= 1'b0;
            ce_pix_out <= 1'b0;
        end else begin
            ce_pix_out <= ce_pix2;
            if (ce_pix2) begin
                hs_out <= hs_d1;
                vs_out <= vs_d1;
                de_out <= de_next;
                r_out  <= de_next ? scanline_dim(rd_data.r, mode) : '0;
                g_out  <= de_next ? scanline_dim(rd_data.g, mode) : '0;
                b_out  <= de_next ? scanline_dim(rd_data.b, mode) : '0;
            end
        end
    end

endmodule

// File: tb/tb_sam_scandoubler.sv
// Randomised scoreboard bench for sam_scandoubler against a line-level reference model.
module tb_sam_scandoubler;

    localparam int LL = 768;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ce_pix, ce_pix2;
    logic       hs_in, vs_in, hblank_in, vblank_in;
    logic [5:0] r_in, g_in, b_in;
    logic [1:0] scanlines;
    logic [5:0] r_out, g_out, b_out;
    logic       hs_out, vs_out, de_out, ce_pix_out;

    sam_scandoubler dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce_pix     (ce_pix),
        .ce_pix2    (ce_pix2),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .hblank_in  (hblank_in),
        .vblank_in  (vblank_in),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .scanlines  (scanlines),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .de_out     (de_out),
        .ce_pix_out (ce_pix_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
    } exp_t;

    typedef struct {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic       blank;
    } pix_t;

    exp_t exp_q[$];
    pix_t cur[$];
    pix_t disp[$];
    int   m_ilen, m_j, m_hslen, m_hcnt;
    logic m_hs_prev, m_vs;
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 0;
    bit   fast = 0;

    function automatic logic [5:0] dim(input logic [5:0] c, input logic second);
        logic [5:0] res;
        res = c;
`ifdef SAM_SCANDOUBLER_SCANLINES_EN
        if (second) begin
            case (scanlines)
                2'd1:    res = c - c / 4;
                2'd2:    res = c / 2;
                2'd3:    res = c / 4;
                default: res = c;
            endcase
        end
`endif
        return res;
    endfunction

    // Output for m_j ce_pix2 pulses after the last input line start.
    function automatic exp_t model_out();
        int   opix;
        logic second;
        exp_t e;
        pix_t p;
        if (m_ilen == 0) begin
            opix = (m_j < LL) ? m_j : LL;
            second = 1'b0;
        end else if (m_j < m_ilen) begin
            opix = m_j;
            second = 1'b0;
        end else begin
            opix = m_j - m_ilen;
            if (opix > LL) opix = LL;
            second = 1'b1;
        end
        e = '0;
        e.hs = (opix < m_hslen);
        e.vs = m_vs;
        if (opix < m_ilen) begin
            p = disp[opix];
            if (!p.blank) begin
                e.de = 1'b1;
                e.r = dim(p.r, second);
                e.g = dim(p.g, second);
                e.b = dim(p.b, second);
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        cur.delete();
        disp.delete();
        m_ilen = 0;
        m_j = 0;
        m_hslen = 0;
        m_hcnt = 0;
        m_hs_prev = 1'b0;
        m_vs = 1'b0;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
    endtask

    task automatic model_step();
        bit   start;
        pix_t p;
        start = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (ce_pix) begin
            if (hs_in && !m_hs_prev) begin
                disp = cur;
                m_ilen = cur.size();
                cur.delete();
                m_hcnt = 1;
                m_j = 0;
                m_vs = vs_in;
                start = 1;
            end else begin
                p.r = r_in;
                p.g = g_in;
                p.b = b_in;
                p.blank = hblank_in | vblank_in;
                if (cur.size() < LL) cur.push_back(p);
                if (hs_in) m_hcnt++;
                if (!hs_in && m_hs_prev) m_hslen = m_hcnt;
            end
            m_hs_prev = hs_in;
        end
        if (ce_pix2) begin
            if (!start && m_j < 100000) m_j++;
            exp_q.push_back(model_out());
        end
    endtask

    task automatic check_reset_zero();
        exp_t got;
        got = {de_out, hs_out, vs_out, r_out, g_out, b_out};
        vectors++;
        if (got !== '0 || ce_pix_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h ce_pix_out=%b, want 0", got, ce_pix_out);
        end
    endtask

    task automatic do_reset(input logic [1:0] sl);
        scanlines = sl;
        for (int i = 0; i < 3; i++) begin
            reset = 1'b1;
            ce_pix = 1'b0;
            ce_pix2 = 1'b0;
            hs_in = 1'b0;
            vs_in = 1'b0;
            @(posedge clk_sys);
            model_step();
            #1;
        end
        check_reset_zero();
        reset = 1'b0;
    endtask

    // One input line: a rising-hs sample followed by n pixel samples; optional reset at sample rst_k.
    task automatic run_line(input int n, input int hsw, input logic vs, input bit ramp,
                            input bit fixed_g, input int rst_k);
        int div;
        int k;
        div = fast ? 2 : 4;
        for (int c = 0; c < (n + 1) * div; c++) begin
            k = c / div;
            reset = (rst_k >= 0) && (c == rst_k * div + 1);
            ce_pix = (c % div == 0);
            ce_pix2 = (c % (div / 2) == 0);
            hs_in = (k < hsw);
            vs_in = vs;
            if (c % div == 0) begin
                hblank_in = (k <= 8);
                vblank_in = ($urandom_range(0, 31) == 0);
                r_in = ramp ? 6'(k - 1) : 6'($urandom);
                g_in = fixed_g ? 6'h3C : 6'($urandom);
                b_in = 6'($urandom);
            end
            @(posedge clk_sys);
            model_step();
            #1;
            if (reset) check_reset_zero();
        end
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t got;
        exp_t want;
        forever begin
            @(posedge clk_sys);
            #1;
            if (ce_pix_out === 1'b1 && !done) begin
                got = {de_out, hs_out, vs_out, r_out, g_out, b_out};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty: got %h, no expected entry", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        miscompares++;
                        if (miscompares <= 30)
                            $display("FAIL pixel @%0t: got de=%b hs=%b vs=%b rgb=%h/%h/%h, want de=%b hs=%b vs=%b rgb=%h/%h/%h",
                                     $time, got.de, got.hs, got.vs, got.r, got.g, got.b,
                                     want.de, want.hs, want.vs, want.r, want.g, want.b);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        ce_pix = 1'b0;
        ce_pix2 = 1'b0;
        hs_in = 1'b0;
        vs_in = 1'b0;
        hblank_in = 1'b0;
        vblank_in = 1'b0;
        r_in = '0;
        g_in = '0;
        b_in = '0;
        scanlines = '0;

        // 6 MHz in, 384-pixel ramp lines
        fast = 0;
        do_reset(2'($urandom));
        for (int l = 0; l < 4; l++) run_line(384, 32, logic'(l == 2), 1, 0, -1);

        // 12 MHz in, full 768-pixel lines
        fast = 1;
        do_reset(2'($urandom));
        for (int l = 0; l < 3; l++) run_line(768, 32, logic'(l == 1), 0, 0, -1);

        // Over-long lines: pixels past 767 dropped
        do_reset(2'($urandom));
        for (int l = 0; l < 3; l++) run_line(900, 20, 1'b0, 0, 0, -1);

        // Reset while ipix = 200
        fast = 0;
        do_reset(2'($urandom));
        run_line(384, 32, 1'b0, 1, 0, -1);
        run_line(384, 32, 1'b0, 1, 0, -1);
        run_line(384, 32, 1'b0, 1, 0, 201);
        for (int l = 0; l < 3; l++) run_line(384, 32, 1'b0, 1, 0, -1);

        // 50% scanlines on a constant green
        do_reset(2'd2);
        for (int l = 0; l < 3; l++) run_line(384, 32, 1'b0, 0, 1, -1);

        done = 1;
        @(posedge clk_sys);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sam_scandoubler.md
Name: sam_scandoubler

Overview:
- Line-doubling stage directly downstream of the SAM Coupe video controller.
- Accepts the controller's 15.6 kHz pixel stream (6 or 12 MHz pixel enables, per-line 512 mode) into a ping-pong line buffer.
- Replays each stored line twice at double pixel rate, giving 31.2 kHz RGB/HS/VS/DE to the VGA pins.

Parameters:
- LINE_LENGTH, 768: maximum stored pixels per input line.
- DW, 6: bits per colour channel.

Ports:
- clk_sys  in  1  master clock
- reset  in  1  synchronous, active-high
- ce_pix  in  1  input pixel enable
- ce_pix2  in  1  output pixel enable at twice ce_pix rate; every ce_pix pulse coincides with a ce_pix2 pulse
- hs_in, vs_in  in  1 each  input syncs, active-high
- hblank_in, vblank_in  in  1 each  input blanking
- r_in, g_in, b_in  in  DW each  input colour
- scanlines  in  2  scanline mode (see Optional Feature)
- r_out, g_out, b_out  out  DW each  doubled colour
- hs_out, vs_out  out  1 each  doubled syncs, active-high
- de_out  out  1  display enable
- ce_pix_out  out  1  copy of ce_pix2, one clk_sys later

Behaviour:
- Reset: all outputs 0. ipix, opix, ilen, hslen, oline and wbank are set to 0.
- Input side (ce_pix only):
  - Rising edge of hs_in, sampled at ce_pix:
    - ilen <= min(ipix, LINE_LENGTH)
    - ipix <= 0, wbank toggles
    - hs width counter restarts
  - Otherwise ipix increments, saturating at LINE_LENGTH.
  - While hs_in is high, the width counter counts input pixels. hslen latches it on the falling edge.
  - Each ce_pix with ipix < LINE_LENGTH writes {r,g,b,blank} to bank wbank, address ipix. blank = hblank_in | vblank_in.
  - Writes with ipix >= LINE_LENGTH are dropped.
- Output side (ce_pix2 only), reading bank ~wbank:
  - On the same ce_pix2 that toggles wbank: opix <= 0, oline <= 0, and vs_out_pre <= vs_in.
  - Else if opix == ilen-1 and ilen != 0: opix <= 0, oline <= 1.
  - Else opix increments, saturating at LINE_LENGTH.
  - Input line restart takes priority over wrap when both occur on the same pulse.
  - After oline = 1 wraps, opix keeps counting until the next input hs. No third replay.
- Latency:
  - Read address registered at ce_pix2 n. RAM data valid at n+1. Output registers load at n+2.
  - hs_pre (opix < hslen), vs_out_pre and oline are delayed 2 ce_pix2 pulses to stay aligned with the pixel data.
  - End to end, a pixel written on input line L appears on output lines 2L and 2L+1.
- Output values:
  - de_out = ~blank & (opix_d2 < ilen).
  - Colour outputs are forced to 0 when de_out is 0.
- ilen == 0 (first line after reset, or an hs with no pixels): outputs 0, hs_out low.
- Reset mid-line: immediate return to reset state. The first complete line after reset produces valid output from the following line onward.

Optional Feature:
- Macro SAM_SCANDOUBLER_SCANLINES_EN.
- Defined: on output lines with oline = 1, each colour c is replaced per scanlines:
  - 0: c
  - 1: c - (c>>2)
  - 2: c>>1
  - 3: c>>2
- Applied in the final output register, with no extra latency.
- Undefined: the scanlines port is present but ignored, and both replays are identical.

Decomposition:
- Package sam_video_pkg:
  - SAM_LINE_LENGTH = 768 and SAM_DW = 6
  - typedef rgbb_t: packed {r, g, b, blank}, 3*DW+1 bits
  - enum scanline_mode_t: NONE, P75, P50, P25
- Sub-module sam_line_ram:
  - simple dual-port, 2*LINE_LENGTH x rgbb_t
  - write port {bank, addr}, read port {bank, addr}, registered read, no reset
  - infers block RAM

Test Plan:
- Line 0 at ce_pix 6 MHz, ce_pix2 12 MHz, 384-pixel lines, ramp r_in = ipix[5:0] -> line 1 outputs two 384-pixel lines with r_out = 0..63 repeating; ilen = 384.
- Per-line 12 MHz input (768 pixels), ce_pix2 = 24 MHz -> ilen = 768 and two replays of 768 pixels; pixel 767 is present on both.
- Input line of 900 pixels -> ilen = 768, writes for pixels 768..899 dropped, no wrap past 767.
- hs_in 32 input pixels wide -> hs_out high for exactly 32 ce_pix2 pulses at the start of each output line, aligned 2 pulses after opix = 0.
- Reset asserted at ipix = 200 -> all outputs 0 next clock. After reset, the first line outputs blank and the second line outputs valid data.
- Macro defined, scanlines = 2, g_in = 6'h3C -> oline 0 g_out = 6'h3C, oline 1 g_out = 6'h1E. Macro undefined -> both lines 6'h3C.
